// File: rtl/palette_ram_fade.sv
// Palette lookup with a 2-stage pipeline and a frame-driven brightness fader.
// Stage 1 reads the palette register array; stage 2 scales each channel by
// (level+1)/16, using whatever level holds when stage 2 captures.
module palette_ram_fade #(
  parameter int INDEX_W     = 4,
  parameter int COLOR_W     = 4,
  parameter int TRANSP_IDX  = 0,
  parameter int FADE_PERIOD = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 rd_valid,
  input  logic [INDEX_W-1:0]   rd_index,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_addr,
  input  logic [3*COLOR_W-1:0] wr_data,
  input  logic                 frame_tick,
  input  logic                 fade_in,
  input  logic                 fade_out,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 pix_valid,
  output logic                 pix_transparent,
  output logic                 fade_busy,
  output logic                 fade_done,
  output logic [3:0]           level
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int PIX_W   = 3 * COLOR_W;
  localparam int TICK_W  = (FADE_PERIOD > 1) ? $clog2(FADE_PERIOD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_FADE_OUT = 2'd2
  } state_e;

  // Reset contents: entry i is a grey with every channel equal to i's low bits.
  function automatic logic [PIX_W-1:0] grey_entry(input int idx);
    logic [COLOR_W-1:0] ch;
    ch = COLOR_W'(idx);
    return {ch, ch, ch};
  endfunction

  // (c * (lvl+1)) >> 4 computed in COLOR_W+5 bits, truncated back to COLOR_W.
  function automatic logic [COLOR_W-1:0] scale_chan(input logic [COLOR_W-1:0] c,
                                                    input logic [3:0] lvl);
    logic [COLOR_W+4:0] prod;
    prod = (COLOR_W+5)'(c) * (COLOR_W+5)'({1'b0, lvl} + 5'd1);
    return COLOR_W'(prod >> 4);
  endfunction

  logic [PIX_W-1:0]   palette_q [ENTRIES];
  logic               s1_valid_q;
  logic [PIX_W-1:0]   s1_pix_q;
  logic               s1_transp_q;
  logic               pv_q;
  logic               transp_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [3:0]         level_q, level_d;
  logic               done_q, done_d;

  // Palette storage: grey ramp on reset, single-entry runtime writes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) palette_q[i] <= grey_entry(i);
    end else if (wr_en) begin
      palette_q[wr_addr] <= wr_data;
    end
  end

  // Stage 1: capture the entry as it stood before any same-edge write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_transp_q <= 1'b0;
    end else begin
      s1_valid_q  <= rd_valid;
      s1_pix_q    <= palette_q[rd_index];
      s1_transp_q <= (rd_index == INDEX_W'(TRANSP_IDX));
    end
  end

  // Stage 2: brightness scaling; outputs forced to zero when not valid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pv_q     <= 1'b0;
      transp_q <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
    end else if (s1_valid_q) begin
      pv_q     <= 1'b1;
      transp_q <= s1_transp_q;
      red_q    <= scale_chan(s1_pix_q[PIX_W-1 -: COLOR_W], level_q);
      green_q  <= scale_chan(s1_pix_q[2*COLOR_W-1 -: COLOR_W], level_q);
      blue_q   <= scale_chan(s1_pix_q[COLOR_W-1:0], level_q);
    end else begin
      pv_q     <= 1'b0;
      transp_q <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
    end
  end

  // Fade state register, tick counter, brightness level and done pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      level_q <= 4'd15;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      done_q  <= done_d;
    end
  end

  // Fade next-state: requests win over ticks; fade_out wins over fade_in.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    level_d = level_q;
    done_d  = 1'b0;
    if (fade_out) begin
      tick_d = '0;
      if (level_q == 4'd0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_FADE_OUT;
      end
    end else if (fade_in) begin
      tick_d = '0;
      if (level_q == 4'd15) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_FADE_IN;
      end
    end else begin
      case (state_q)
        ST_FADE_IN: begin
          if (frame_tick) begin
            if (tick_q == TICK_W'(FADE_PERIOD - 1)) begin
              tick_d  = '0;
              level_d = level_q + 4'd1;
              if (level_q == 4'd14) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_FADE_IN;
              end
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
          end else begin
            tick_d = tick_q;
          end
        end
        ST_FADE_OUT: begin
          if (frame_tick) begin
            if (tick_q == TICK_W'(FADE_PERIOD - 1)) begin
              tick_d  = '0;
              level_d = level_q - 4'd1;
              if (level_q == 4'd1) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_FADE_OUT;
              end
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
          end else begin
            tick_d = tick_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tick_d  = tick_q;
        end
      endcase
    end
  end

  assign red             = red_q;
  assign green           = green_q;
  assign blue            = blue_q;
  assign pix_valid       = pv_q;
  assign pix_transparent = transp_q;
  assign fade_busy       = (state_q != ST_IDLE);
  assign fade_done       = done_q;
  assign level           = level_q;

endmodule

// File: tb/tb_palette_ram_fade.sv
// Directed plus randomized bench for palette_ram_fade with a behavioural model.
module tb_palette_ram_fade;
  localparam int IW = 4;
  localparam int CW = 4;
  localparam int TI = 0;
  localparam int FP = 4;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Reset, rd_valid, wr_en, frame_tick, fade_in, fade_out;
  logic [IW-1:0] rd_index, wr_addr;
  logic [11:0]   wr_data;
  logic [CW-1:0] red, green, blue;
  logic [3:0]    level;
  logic          pix_valid, pix_transparent, fade_busy, fade_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_pal[16];
  int m_lvl, m_mode, m_cnt;   // mode: 0 idle, 1 brightening, 2 darkening
  bit m_done;
  bit m_s1_v, m_s1_t;
  int m_s1_rgb;
  bit m_o_v, m_o_t;
  int m_o_r, m_o_g, m_o_b;

  palette_ram_fade #(.INDEX_W(IW), .COLOR_W(CW), .TRANSP_IDX(TI), .FADE_PERIOD(FP)) dut (
    .Clk(Clk), .Reset(Reset), .rd_valid(rd_valid), .rd_index(rd_index),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_tick(frame_tick),
    .fade_in(fade_in), .fade_out(fade_out), .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_transparent(pix_transparent), .fade_busy(fade_busy),
    .fade_done(fade_done), .level(level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int scale(input int c, input int l);
    return (c * (l + 1)) / 16;
  endfunction

  // One clock edge: update the model from the stable inputs, then compare.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (Reset) begin
      for (int i = 0; i < 16; i++) m_pal[i] = i * 'h111;
      m_s1_v = 0; m_s1_t = 0; m_s1_rgb = 0;
      m_o_v = 0; m_o_t = 0; m_o_r = 0; m_o_g = 0; m_o_b = 0;
      m_lvl = 15; m_mode = 0; m_cnt = 0; m_done = 0;
    end else begin
      m_o_v = m_s1_v;
      m_o_t = m_s1_v && m_s1_t;
      m_o_r = m_s1_v ? scale((m_s1_rgb >> 8) & 15, m_lvl) : 0;
      m_o_g = m_s1_v ? scale((m_s1_rgb >> 4) & 15, m_lvl) : 0;
      m_o_b = m_s1_v ? scale(m_s1_rgb & 15, m_lvl) : 0;
      m_s1_v = rd_valid;
      m_s1_rgb = m_pal[rd_index];
      m_s1_t = (int'(rd_index) == TI);
      if (wr_en) m_pal[wr_addr] = int'(wr_data);
      m_done = 0;
      if (fade_out) begin
        m_cnt = 0;
        if (m_lvl == 0) begin m_mode = 0; m_done = 1; end else m_mode = 2;
      end else if (fade_in) begin
        m_cnt = 0;
        if (m_lvl == 15) begin m_mode = 0; m_done = 1; end else m_mode = 1;
      end else if (m_mode != 0 && frame_tick) begin
        m_cnt++;
        if (m_cnt == FP) begin
          m_cnt = 0;
          m_lvl = (m_mode == 1) ? m_lvl + 1 : m_lvl - 1;
          if ((m_mode == 1 && m_lvl == 15) || (m_mode == 2 && m_lvl == 0)) begin
            m_mode = 0;
            m_done = 1;
          end
        end
      end
    end
    check("pix_valid", pix_valid, m_o_v);
    check("red", red, m_o_r);
    check("green", green, m_o_g);
    check("blue", blue, m_o_b);
    check("pix_transparent", pix_transparent, m_o_t);
    check("level", level, m_lvl);
    check("fade_busy", fade_busy, m_mode != 0);
    check("fade_done", fade_done, m_done);
  endtask

  initial begin
    Reset = 1; rd_valid = 0; rd_index = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    frame_tick = 0; fade_in = 0; fade_out = 0;
    tick(); tick();
    Reset = 0;
    check("rst_level", level, 4'd15);
    check("rst_pix", {pix_valid, red, green, blue, pix_transparent}, 14'd0);
    check("rst_busy_done", {fade_busy, fade_done}, 2'b00);

    // Grey ramp lookups and transparency
    rd_valid = 1; rd_index = 4'd5; tick();
    rd_index = 4'd0; tick();
    check("grey5_valid", pix_valid, 1'b1);
    check("grey5_rgb", {red, green, blue}, 12'h555);
    check("grey5_transp", pix_transparent, 1'b0);
    rd_valid = 0; tick();
    check("idx0_transp", pix_transparent, 1'b1);
    tick();
    check("invalid_zero", {pix_valid, red, green, blue, pix_transparent}, 14'd0);

    // Same-cycle write/read returns old contents
    wr_en = 1; wr_addr = 4'd3; wr_data = 12'hF80; rd_valid = 1; rd_index = 4'd3; tick();
    wr_en = 0; tick();
    check("wr_same_cycle", {red, green, blue}, 12'h333);
    rd_valid = 0; tick();
    check("wr_next_cycle", {red, green, blue}, 12'hF80);

    // Full fade-out
    fade_out = 1; tick(); fade_out = 0;
    check("fo_busy", fade_busy, 1'b1);
    for (int k = 1; k <= 60; k++) begin
      frame_tick = 1; tick(); frame_tick = 0;
      if (k == 4) check("fo_level_after4", level, 4'd14);
      if (k == 60) begin
        check("fo_level_end", level, 4'd0);
        check("fo_done", fade_done, 1'b1);
        check("fo_busy_fall", fade_busy, 1'b0);
      end else begin
        check("fo_no_done", fade_done, 1'b0);
      end
      tick();
    end
    check("fo_done_single", fade_done, 1'b0);

    // Level 0 darkens a white entry fully
    wr_en = 1; wr_addr = 4'd9; wr_data = 12'hFFF; tick(); wr_en = 0;
    rd_valid = 1; rd_index = 4'd9; tick(); rd_valid = 0; tick();
    check("lvl0_rgb", {pix_valid, red, green, blue}, 13'h1000);

    // Fade-out request already at black
    fade_out = 1; tick(); fade_out = 0;
    check("fo_at0_done", {fade_done, fade_busy, level}, 6'b10_0000);
    tick();
    check("fo_at0_pulse", fade_done, 1'b0);

    // Fade in to level 7 and read white
    fade_in = 1; tick(); fade_in = 0;
    for (int k = 0; k < 28; k++) begin
      frame_tick = 1; tick(); frame_tick = 0; tick();
    end
    check("fi_level7", level, 4'd7);
    rd_valid = 1; rd_index = 4'd9; tick(); rd_valid = 0; tick();
    check("lvl7_rgb", {red, green, blue}, 12'h777);

    // Reset mid-fade with a lookup in flight
    rd_valid = 1; rd_index = 4'd9; tick(); rd_valid = 0;
    Reset = 1; tick(); Reset = 0;
    check("rst_mid_level", level, 4'd15);
    check("rst_mid_busy", fade_busy, 1'b0);
    tick();
    check("rst_mid_nopix", pix_valid, 1'b0);

    // Fade-in request already at full
    fade_in = 1; tick(); fade_in = 0;
    check("fi_at15", {fade_done, fade_busy, level}, 6'b10_1111);

    // Both requests together behave as fade-out
    fade_in = 1; fade_out = 1; tick(); fade_in = 0; fade_out = 0;
    check("both_busy", fade_busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      frame_tick = 1; tick(); frame_tick = 0; tick();
    end
    check("both_is_out", level, 4'd14);

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      Reset      = ($urandom_range(0, 299) == 0);
      rd_valid   = 1'($urandom_range(0, 1));
      rd_index   = 4'($urandom_range(0, 15));
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_addr    = 4'($urandom_range(0, 15));
      wr_data    = 12'($urandom_range(0, 4095));
      frame_tick = 1'($urandom_range(0, 1));
      fade_in    = ($urandom_range(0, 49) == 0);
      fade_out   = ($urandom_range(0, 69) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
